// File: rtl/frame_serializer.sv
// Parallel-to-serial frame transmitter: {stop=1, data, start=0}, LSB first.
// One-word holding buffer allows back-to-back frames with no idle bits.
module frame_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int IDLE_GAP   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic                  out_bit,
    output logic                  busy
);

    localparam int FRAME_LEN = DATA_WIDTH + 2;
    localparam int CW        = $clog2(FRAME_LEN);
    localparam int GW        = (IDLE_GAP > 0) ? $clog2(IDLE_GAP + 1) : 1;
    localparam int GAP_LAST  = (IDLE_GAP > 0) ? IDLE_GAP - 1 : 0;
    localparam logic [CW-1:0] BIT_LAST = CW'(FRAME_LEN - 1);
    localparam logic [GW-1:0] GAP_END  = GW'(GAP_LAST);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [FRAME_LEN-1:0]    shreg;
    logic [CW-1:0]           bit_cnt;
    logic [GW-1:0]           gap_cnt;
    logic [DATA_WIDTH-1:0]   hold_data;
    logic                    hold_full;
    logic                    hold_next;

    logic                    last_bit;
    logic                    gap_end;
    logic                    free;
    logic                    xfer;
    logic                    load_hold;
    logic                    load_in;
    logic                    load;
    logic                    to_hold;
    logic [DATA_WIDTH-1:0]   load_word;
    logic [FRAME_LEN-1:0]    frame;

    always_comb begin
        last_bit  = (state == SEND) && (bit_cnt == BIT_LAST);
        gap_end   = (state == GAP) && (gap_cnt == GAP_END);
        free      = (state == IDLE) || (last_bit && (IDLE_GAP == 0)) || gap_end;
        xfer      = data_valid && data_ready;
        load_hold = free && hold_full;
        load_in   = free && !hold_full && xfer;
        load      = load_hold || load_in;
        // ready is only high with the buffer empty, so a buffering
        // transfer never collides with a buffer drain
        to_hold   = xfer && !load_in;
        load_word = hold_full ? hold_data : data_in;
        frame     = {1'b1, load_word, 1'b0};

        hold_next = hold_full;
        if (to_hold) begin
            hold_next = 1'b1;
        end else if (load_hold) begin
            hold_next = 1'b0;
        end

        state_next = state;
        if (load) begin
            state_next = SEND;
        end else if (last_bit) begin
            state_next = (IDLE_GAP > 0) ? GAP : IDLE;
        end else if (gap_end) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '1;
            out_bit    <= 1'b1;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            hold_data  <= '0;
            hold_full  <= 1'b0;
            data_ready <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            hold_full  <= hold_next;
            data_ready <= !hold_next;
            busy       <= (state_next != IDLE) || hold_next;

            if (to_hold) begin
                hold_data <= data_in;
            end

            if (load) begin
                out_bit <= frame[0];
                shreg   <= {1'b1, frame[FRAME_LEN-1:1]};
                bit_cnt <= '0;
            end else if (state == SEND) begin
                out_bit <= shreg[0];
                shreg   <= {1'b1, shreg[FRAME_LEN-1:1]};
                if (last_bit) begin
                    bit_cnt <= '0;
                    gap_cnt <= '0;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end else if (state == GAP) begin
                out_bit <= 1'b1;
                if (!gap_end) begin
                    gap_cnt <= gap_cnt + 1'b1;
                end
            end else begin
                out_bit <= 1'b1;
            end
        end
    end

endmodule
